// File: rtl/count_chk_pkg.sv
// Shared types and constants for the count sequence checker.
// The prediction helper lives here so the step predictor and the top-level
// o_expect register use the same rule for the next counter value.
package count_chk_pkg;

   // Width of the observed counter value
   localparam int CNT_W      = 3;

   // Default consecutive good steps needed to lock (legal range 1..7)
   localparam int LOCK_N_DEF = 2;

   // Default width of the saturating error counter
   localparam int ERR_W_DEF  = 8;

   // Checker state: no reference, acquiring, locked
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Next value of a modulo-2^CNT_W counter stepping up (up=1) or down (up=0)
   function automatic logic [CNT_W-1:0] step_expect(input logic [CNT_W-1:0] cur,
                                                    input logic             up);
      return up ? cur + CNT_W'(1) : cur - CNT_W'(1);
   endfunction

endpackage

// File: rtl/count_step_pred.sv
// Combinational step predictor: given the reference value and the claimed
// direction, produce the value the next sample must carry and flag whether
// that step is a wrap (7->0 counting up, 0->7 counting down).
module count_step_pred
   import count_chk_pkg::*;
(
   input  logic [CNT_W-1:0] in_ref,
   input  logic             in_m,
   output logic [CNT_W-1:0] o_expect,
   output logic             o_wrap
);

   // Prediction and wrap detection for one step
   always_comb begin
      o_expect = step_expect(in_ref, in_m);
      o_wrap   = in_m ? (in_ref == {CNT_W{1'b1}}) : (in_ref == {CNT_W{1'b0}});
   end

endmodule

// File: rtl/count_seq_checker.sv
// Count sequence checker: watches a 3-bit counter plus its claimed direction,
// acquires lock after LOCK_N consecutive correct steps, then reports each
// step mismatch as a one-cycle o_err pulse and counts it (saturating).
// Correct wrap steps are flagged on o_wrap. All outputs are registered with
// one cycle of latency after the sampling edge.
// Optional build macro COUNT_SEQ_STICKY_EN adds o_err_sticky, set by any
// o_err pulse and cleared only by reset.
module count_seq_checker
   import count_chk_pkg::*;
#(
   parameter int LOCK_N = LOCK_N_DEF,
   parameter int ERR_W  = ERR_W_DEF
)
(
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic             in_valid,
   input  logic [CNT_W-1:0] in_q,
   input  logic             in_m,
   output logic             o_locked,
   output logic             o_err,
   output logic             o_wrap,
   output logic [CNT_W-1:0] o_expect,
`ifdef COUNT_SEQ_STICKY_EN
   output logic             o_err_sticky,
`endif
   output logic [ERR_W-1:0] o_err_cnt
);

   // Registered state
   state_t             r_state;
   logic [2:0]         r_good;
   logic [CNT_W-1:0]   r_ref;
   logic               r_locked;
   logic               r_err;
   logic               r_wrap;
   logic [CNT_W-1:0]   r_expect;
   logic [ERR_W-1:0]   r_err_cnt;

   // Combinational next-state and pulse decisions
   state_t             w_state_nxt;
   logic [2:0]         w_good_nxt;
   logic               w_err;
   logic               w_wrap;

   // Prediction for the sample arriving now
   logic [CNT_W-1:0]   w_pred;
   logic               w_pred_wrap;
   logic               w_match;

   // The current sample is judged against its own in_m, so a direction change
   // between samples is legal. A repeated value can never equal ref+/-1.
   count_step_pred u_pred (
      .in_ref   (r_ref),
      .in_m     (in_m),
      .o_expect (w_pred),
      .o_wrap   (w_pred_wrap)
   );

   assign w_match = (in_q == w_pred);

   // State register and good-step counter; reset discards any sample in flight
   always_ff @(posedge in_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (in_rst) begin
         r_state <= IDLE;
         r_good  <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_good  <= w_good_nxt;
      end
   end

   // Next-state logic plus err/wrap decisions for the current sample
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would infer a latch.
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_err       = 1'b0;
      w_wrap      = 1'b0;

      if (in_valid) begin
         unique case (r_state)
            IDLE: begin
               // First sample only establishes the reference
               w_state_nxt = ACQ;
               w_good_nxt  = 3'd0;
            end
            ACQ: begin
               if (w_match) begin
                  w_good_nxt = r_good + 3'd1;
                  w_wrap     = w_pred_wrap;
                  if ((r_good + 3'd1) == 3'(LOCK_N)) begin
                     w_state_nxt = LOCKED;
                  end
               end else begin
                  // Mismatch while acquiring restarts the count silently
                  w_good_nxt = 3'd0;
               end
            end
            LOCKED: begin
               if (w_match) begin
                  w_wrap = w_pred_wrap;
               end else begin
                  w_err       = 1'b1;
                  w_good_nxt  = 3'd0;
                  w_state_nxt = ACQ;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_good_nxt  = 3'd0;
            end
         endcase
      end
   end

   // Reference, registered outputs and the saturating error counter
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_ref     <= '0;
         r_locked  <= 1'b0;
         r_err     <= 1'b0;
         r_wrap    <= 1'b0;
         r_expect  <= '0;
         r_err_cnt <= '0;
      end else begin
         r_locked <= (w_state_nxt == LOCKED);
         r_err    <= w_err;
         r_wrap   <= w_wrap;
         if (in_valid) begin
            // Every accepted sample becomes the new reference; o_expect is
            // computed from the new reference and this sample's direction.
            // Only reset returns to IDLE, so o_expect stays 0 there.
            r_ref    <= in_q;
            r_expect <= step_expect(in_q, in_m);
         end
         if (w_err && (r_err_cnt != {ERR_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
         end
      end
   end

`ifdef COUNT_SEQ_STICKY_EN
   logic r_err_sticky;

   // Sticky error flag, set alongside any o_err pulse
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_err_sticky <= 1'b0;
      end else if (w_err) begin
         r_err_sticky <= 1'b1;
      end
   end

   assign o_err_sticky = r_err_sticky;
`endif

   assign o_locked  = r_locked;
   assign o_err     = r_err;
   assign o_wrap    = r_wrap;
   assign o_expect  = r_expect;
   assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed testbench for count_seq_checker (LOCK_N=2, ERR_W=8): a table of
// single-cycle vectors followed by a long lock/mismatch loop for counter
// saturation and a reset-with-valid check.
module tb_count_seq_checker;

   logic       in_clk = 1'b0;
   logic       in_rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] in_q = 3'd0;
   logic       in_m = 1'b0;
   logic       o_locked;
   logic       o_err;
   logic       o_wrap;
   logic [2:0] o_expect;
   logic [7:0] o_err_cnt;
`ifdef COUNT_SEQ_STICKY_EN
   logic       o_err_sticky;
`endif

   int total = 0;
   int bad   = 0;

   count_seq_checker #(.LOCK_N(2), .ERR_W(8)) dut (
      .in_clk       (in_clk),
      .in_rst       (in_rst),
      .in_valid     (in_valid),
      .in_q         (in_q),
      .in_m         (in_m),
      .o_locked     (o_locked),
      .o_err        (o_err),
      .o_wrap       (o_wrap),
      .o_expect     (o_expect),
`ifdef COUNT_SEQ_STICKY_EN
      .o_err_sticky (o_err_sticky),
`endif
      .o_err_cnt    (o_err_cnt)
   );

   always #5 in_clk = ~in_clk;

   typedef struct {
      int rst;
      int valid;
      int q;
      int m;
      int locked;
      int err;
      int wrap;
      int expect_v;
      int cnt;
   } vec_t;

   vec_t vecs[33];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample outputs 1ns after the rising edge
   task automatic drive(input int rst, input int valid, input int q, input int m);
      @(negedge in_clk);
      in_rst   = rst[0];
      in_valid = valid[0];
      in_q     = 3'(q);
      in_m     = m[0];
      @(posedge in_clk);
      #1;
   endtask

   initial begin
      logic [2:0] r;

      //            rst val q  m  lock err wrap exp cnt
      vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};  // reset state
      vecs[1]  = '{0, 1, 0, 1, 0, 0, 0, 1, 0};  // IDLE -> ACQ
      vecs[2]  = '{0, 1, 1, 1, 0, 0, 0, 2, 0};
      vecs[3]  = '{0, 1, 2, 1, 1, 0, 0, 3, 0};  // locks after sample 2
      vecs[4]  = '{0, 1, 3, 1, 1, 0, 0, 4, 0};
      vecs[5]  = '{0, 1, 4, 1, 1, 0, 0, 5, 0};
      vecs[6]  = '{0, 1, 5, 1, 1, 0, 0, 6, 0};
      vecs[7]  = '{0, 1, 6, 1, 1, 0, 0, 7, 0};
      vecs[8]  = '{0, 1, 7, 1, 1, 0, 0, 0, 0};
      vecs[9]  = '{0, 1, 0, 1, 1, 0, 1, 1, 0};  // up wrap 7->0
      vecs[10] = '{0, 0, 5, 0, 1, 0, 0, 1, 0};  // valid low holds
      vecs[11] = '{0, 1, 1, 1, 1, 0, 0, 2, 0};
      vecs[12] = '{0, 1, 2, 1, 1, 0, 0, 3, 0};
      vecs[13] = '{0, 1, 3, 1, 1, 0, 0, 4, 0};
      vecs[14] = '{0, 1, 4, 1, 1, 0, 0, 5, 0};
      vecs[15] = '{0, 1, 5, 1, 1, 0, 0, 6, 0};
      vecs[16] = '{0, 1, 5, 1, 0, 1, 0, 6, 1};  // repeat while locked -> err
      vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 6, 1};  // err is one cycle
      vecs[18] = '{0, 1, 0, 1, 0, 0, 0, 1, 1};  // ACQ mismatch, no err
      vecs[19] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};  // reset
      vecs[20] = '{0, 1, 2, 1, 0, 0, 0, 3, 0};
      vecs[21] = '{0, 1, 3, 1, 0, 0, 0, 4, 0};
      vecs[22] = '{0, 1, 2, 0, 1, 0, 0, 1, 0};  // direction change matches
      vecs[23] = '{0, 1, 1, 0, 1, 0, 0, 0, 0};
      vecs[24] = '{0, 1, 0, 0, 1, 0, 0, 7, 0};
      vecs[25] = '{0, 1, 7, 0, 1, 0, 1, 6, 0};  // down wrap 0->7
      vecs[26] = '{1, 1, 6, 0, 0, 0, 0, 0, 0};  // reset beats valid
      vecs[27] = '{0, 1, 5, 0, 0, 0, 0, 4, 0};  // discarded sample: IDLE->ACQ
      vecs[28] = '{0, 1, 4, 0, 0, 0, 0, 3, 0};  // only one good step so far
      vecs[29] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[30] = '{0, 1, 7, 1, 0, 0, 0, 0, 0};  // IDLE sample never wraps
      vecs[31] = '{0, 1, 0, 1, 0, 0, 1, 1, 0};  // wrap in ACQ
      vecs[32] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};  // ACQ mismatch

      for (int i = 0; i < 33; i++) begin
         drive(vecs[i].rst, vecs[i].valid, vecs[i].q, vecs[i].m);
         check($sformatf("v%0d locked", i), int'(o_locked),  vecs[i].locked);
         check($sformatf("v%0d err", i),    int'(o_err),     vecs[i].err);
         check($sformatf("v%0d wrap", i),   int'(o_wrap),    vecs[i].wrap);
         check($sformatf("v%0d expect", i), int'(o_expect),  vecs[i].expect_v);
         check($sformatf("v%0d err_cnt", i), int'(o_err_cnt), vecs[i].cnt);
      end

      // Saturation: lock with two up-steps, then repeat a value, 260 times
      drive(1, 0, 0, 0);
      drive(0, 1, 0, 1);
      r = 3'd0;
      for (int i = 0; i < 260; i++) begin
         drive(0, 1, int'(3'(r + 3'd1)), 1);
         drive(0, 1, int'(3'(r + 3'd2)), 1);
         check($sformatf("sat%0d locked", i), int'(o_locked), 1);
         drive(0, 1, int'(3'(r + 3'd2)), 1);
         check($sformatf("sat%0d err", i), int'(o_err), 1);
         check($sformatf("sat%0d err_cnt", i), int'(o_err_cnt),
               (i + 1 > 255) ? 255 : i + 1);
         r = 3'(r + 3'd2);
      end

      // Re-lock, then reset together with a valid sample while locked
      drive(0, 1, int'(3'(r + 3'd1)), 1);
      drive(0, 1, int'(3'(r + 3'd2)), 1);
      check("relock locked", int'(o_locked), 1);
      check("relock err_cnt held", int'(o_err_cnt), 255);
`ifdef COUNT_SEQ_STICKY_EN
      check("sticky set", int'(o_err_sticky), 1);
`endif
      drive(1, 1, int'(3'(r + 3'd3)), 1);
      check("rst+valid locked", int'(o_locked),  0);
      check("rst+valid err",    int'(o_err),     0);
      check("rst+valid wrap",   int'(o_wrap),    0);
      check("rst+valid expect", int'(o_expect),  0);
      check("rst+valid err_cnt", int'(o_err_cnt), 0);
`ifdef COUNT_SEQ_STICKY_EN
      check("sticky cleared", int'(o_err_sticky), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
